// File: rtl/piso_stream_pkg.sv
// Shared definitions for the bit-serial converters: shifter FSM states and bit selection.
package piso_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // Picks transmission-order bit cnt of a word whose top bit index is top.
  function automatic logic bit_sel(input logic [MAX_W-1:0] word,
                                   input logic [5:0]       cnt,
                                   input logic             lsb_first,
                                   input logic [5:0]       top);
    logic [5:0] idx;
    idx = lsb_first ? cnt : (top - cnt);
    return word[idx];
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Word-in / bit-out stream bundle; slave is the converter's view, master the environment's.
interface piso_stream_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              lsb_first;
  logic              sout;
  logic              sout_valid;
  logic              sout_ready;
  logic              sout_first;
  logic              sout_last;
  logic              busy;

  modport slave (input  in_data, in_valid, lsb_first, sout_ready,
                 output in_ready, sout, sout_valid, sout_first, sout_last, busy);
  modport master(output in_data, in_valid, lsb_first, sout_ready,
                 input  in_ready, sout, sout_valid, sout_first, sout_last, busy);
endinterface

// File: rtl/piso_stream_hold_reg.sv
// One-entry skid register: captures a word and its order flag on load, empties on drain.
module piso_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_lsb,
  output logic [DATA_W-1:0] q_data,
  output logic              q_lsb,
  output logic              full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_data <= '0;
      q_lsb  <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (load) begin
        q_data <= d_data;
        q_lsb  <= d_lsb;
      end
      // load and drain never coincide: a load needs the entry empty
      if (load)       full <= 1'b1;
      else if (drain) full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out converter: word handshake in, one bit per handshake out,
// per-word MSB/LSB order, with a one-word holding register for gapless streaming.
module piso_stream
  import piso_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  piso_stream_if.slave   s
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [5:0]      TOP_IDX  = 6'(DATA_W - 1);

  state_t            state_p0, nxt_state;
  logic [DATA_W-1:0] word_p0, nxt_word;
  logic              lsb_p0, nxt_lsb;
  logic [CNT_W-1:0]  cnt_p0, nxt_cnt;
  logic              vld_p0;

  logic [DATA_W-1:0] hold_data;
  logic              hold_lsb;
  logic              hold_full;

  logic accept, xfer, end_word, shifter_free, bypass, hold_load, hold_drain;

  assign vld_p0       = (state_p0 == S_SHIFT);
  assign accept       = s.in_valid && !hold_full;
  assign xfer         = vld_p0 && s.sout_ready;
  assign end_word     = xfer && s.sout_last;
  assign shifter_free = !vld_p0 || end_word;
  assign bypass       = accept && shifter_free;
  assign hold_load    = accept && !shifter_free;
  assign hold_drain   = end_word && hold_full;

  assign s.in_ready   = !hold_full;
  assign s.sout_valid = vld_p0;
  assign s.busy       = vld_p0 || hold_full;

  piso_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .load   (hold_load),
    .drain  (hold_drain),
    .d_data (s.in_data),
    .d_lsb  (s.lsb_first),
    .q_data (hold_data),
    .q_lsb  (hold_lsb),
    .full   (hold_full)
  );

  // Held word has priority at end of word; input can only bypass when the hold is empty.
  always_comb begin
    nxt_state = state_p0;
    nxt_word  = word_p0;
    nxt_lsb   = lsb_p0;
    nxt_cnt   = cnt_p0;
    if (hold_drain) begin
      nxt_state = S_SHIFT;
      nxt_word  = hold_data;
      nxt_lsb   = hold_lsb;
      nxt_cnt   = '0;
    end else if (bypass) begin
      nxt_state = S_SHIFT;
      nxt_word  = s.in_data;
      nxt_lsb   = s.lsb_first;
      nxt_cnt   = '0;
    end else if (end_word) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
    end else if (xfer) begin
      nxt_cnt   = cnt_p0 + 1'b1;
    end
  end

  // Serial outputs are registered from the next-state word/counter so they change with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0     <= S_IDLE;
      word_p0      <= '0;
      lsb_p0       <= 1'b0;
      cnt_p0       <= '0;
      s.sout       <= 1'b0;
      s.sout_first <= 1'b0;
      s.sout_last  <= 1'b0;
    end else begin
      state_p0     <= nxt_state;
      word_p0      <= nxt_word;
      lsb_p0       <= nxt_lsb;
      cnt_p0       <= nxt_cnt;
      s.sout       <= (nxt_state == S_SHIFT) &&
                      bit_sel(MAX_W'(nxt_word), 6'(nxt_cnt), nxt_lsb, TOP_IDX);
      s.sout_first <= (nxt_state == S_SHIFT) && (nxt_cnt == '0);
      s.sout_last  <= (nxt_state == S_SHIFT) && (nxt_cnt == CNT_LAST);
    end
  end

endmodule
